// File: rtl/lc3b_control_if.sv
// Memory handshake bundle between the LC-3b control FSM and the memory model.
// master: control unit (issues read/write, receives mem_resp).
// slave : memory model.
interface lc3b_control_if;
  logic       mem_read;
  logic       mem_write;
  logic [1:0] mem_byte_enable;
  logic       mem_resp;

  modport master (
    output mem_read,
    output mem_write,
    output mem_byte_enable,
    input  mem_resp
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  mem_byte_enable,
    output mem_resp
  );
endinterface

// File: rtl/lc3b_control.sv
// Moore control FSM for the LC-3b multicycle core.
// Drives every datapath control input from the current state only, and owns
// the memory handshake through the lc3b_control_if master modport.
// Optional build macro LC3B_CONTROL_ILLEGAL_TRAP_EN: undefined opcodes park
// the FSM in HALT with illegal_op=1 until rst; otherwise they act as NOPs.
module lc3b_control (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    opcode,
  input  logic          branch_enable,
  lc3b_control_if.master mem,
  output logic          load_pc,
  output logic          load_ir,
  output logic          load_regfile,
  output logic          load_mar,
  output logic          load_mdr,
  output logic          load_cc,
  output logic          pcmux_sel,
  output logic          storemux_sel,
  output logic          alumux_sel,
  output logic          regfilemux_sel,
  output logic          marmux_sel,
  output logic          mdrmux_sel,
  output logic [2:0]    aluop,
  output logic          illegal_op
);

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_AND  = 3'd1;
  localparam logic [2:0] ALU_NOT  = 3'd2;
  localparam logic [2:0] ALU_PASS = 3'd3;

  typedef enum logic [3:0] {
    FETCH1,
    FETCH2,
    FETCH3,
    DECODE,
    S_ADD,
    S_AND,
    S_NOT,
    BR,
    BR_TAKEN,
    CALC_ADDR,
    LDR1,
    LDR2,
    STR1,
`ifdef LC3B_CONTROL_ILLEGAL_TRAP_EN
    STR2,
    HALT
`else
    STR2
`endif
  } state_t;

  state_t state;
  state_t state_next;

  // State register; async reset forces FETCH1 so outputs settle before any edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH1;
    else     state <= state_next;
  end

  // Next-state logic plus Moore outputs (outputs decode state only).
  always_comb begin
    state_next          = state;
    load_pc             = 1'b0;
    load_ir             = 1'b0;
    load_regfile        = 1'b0;
    load_mar            = 1'b0;
    load_mdr            = 1'b0;
    load_cc             = 1'b0;
    pcmux_sel           = 1'b0;
    storemux_sel        = 1'b0;
    alumux_sel          = 1'b0;
    regfilemux_sel      = 1'b0;
    marmux_sel          = 1'b0;
    mdrmux_sel          = 1'b0;
    aluop               = ALU_ADD;
    illegal_op          = 1'b0;
    mem.mem_read        = 1'b0;
    mem.mem_write       = 1'b0;
    mem.mem_byte_enable = 2'b11;

    unique case (state)
      FETCH1: begin
        marmux_sel = 1'b1;
        load_mar   = 1'b1;
        load_pc    = 1'b1;
        state_next = FETCH2;
      end
      FETCH2: begin
        mem.mem_read = 1'b1;
        mdrmux_sel   = 1'b1;
        load_mdr     = 1'b1;
        if (mem.mem_resp) state_next = FETCH3;
      end
      FETCH3: begin
        load_ir    = 1'b1;
        state_next = DECODE;
      end
      DECODE: begin
        case (opcode)
          OP_ADD:         state_next = S_ADD;
          OP_AND:         state_next = S_AND;
          OP_NOT:         state_next = S_NOT;
          OP_BR:          state_next = BR;
          OP_LDR, OP_STR: state_next = CALC_ADDR;
`ifdef LC3B_CONTROL_ILLEGAL_TRAP_EN
          default:        state_next = HALT;
`else
          default:        state_next = FETCH1;
`endif
        endcase
      end
      S_ADD, S_AND, S_NOT: begin
        if (state == S_AND)      aluop = ALU_AND;
        else if (state == S_NOT) aluop = ALU_NOT;
        else                     aluop = ALU_ADD;
        load_regfile = 1'b1;
        load_cc      = 1'b1;
        state_next   = FETCH1;
      end
      BR: begin
        state_next = branch_enable ? BR_TAKEN : FETCH1;
      end
      BR_TAKEN: begin
        pcmux_sel  = 1'b1;
        load_pc    = 1'b1;
        state_next = FETCH1;
      end
      CALC_ADDR: begin
        alumux_sel = 1'b1;
        load_mar   = 1'b1;
        state_next = (opcode == OP_LDR) ? LDR1 : STR1;
      end
      LDR1: begin
        mem.mem_read = 1'b1;
        mdrmux_sel   = 1'b1;
        load_mdr     = 1'b1;
        if (mem.mem_resp) state_next = LDR2;
      end
      LDR2: begin
        regfilemux_sel = 1'b1;
        load_regfile   = 1'b1;
        load_cc        = 1'b1;
        state_next     = FETCH1;
      end
      STR1: begin
        storemux_sel = 1'b1;
        aluop        = ALU_PASS;
        load_mdr     = 1'b1;
        state_next   = STR2;
      end
      STR2: begin
        mem.mem_write = 1'b1;
        if (mem.mem_resp) state_next = FETCH1;
      end
`ifdef LC3B_CONTROL_ILLEGAL_TRAP_EN
      HALT: begin
        illegal_op = 1'b1;
      end
`endif
      default: state_next = FETCH1;
    endcase
  end

endmodule

// File: tb/tb_lc3b_control.sv
// Directed testbench for lc3b_control: walks each instruction class state by
// state and compares the full control-output vector against hand-written
// per-state expectations.
module tb_lc3b_control;

  logic       clk;
  logic       rst;
  logic [3:0] opcode;
  logic       branch_enable;
  logic       load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc;
  logic       pcmux_sel, storemux_sel, alumux_sel, regfilemux_sel;
  logic       marmux_sel, mdrmux_sel;
  logic [2:0] aluop;
  logic       illegal_op;

  int unsigned n_tests;
  int unsigned n_fail;

  lc3b_control_if mem ();

  lc3b_control dut (
    .clk            (clk),
    .rst            (rst),
    .opcode         (opcode),
    .branch_enable  (branch_enable),
    .mem            (mem.master),
    .load_pc        (load_pc),
    .load_ir        (load_ir),
    .load_regfile   (load_regfile),
    .load_mar       (load_mar),
    .load_mdr       (load_mdr),
    .load_cc        (load_cc),
    .pcmux_sel      (pcmux_sel),
    .storemux_sel   (storemux_sel),
    .alumux_sel     (alumux_sel),
    .regfilemux_sel (regfilemux_sel),
    .marmux_sel     (marmux_sel),
    .mdrmux_sel     (mdrmux_sel),
    .aluop          (aluop),
    .illegal_op     (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector order:
  // load_pc load_ir load_regfile load_mar load_mdr load_cc | pcmux storemux
  // alumux regfilemux marmux mdrmux | aluop[2:0] | mem_read mem_write illegal_op
  localparam logic [17:0] E_FETCH1 = 18'b1_0_0_1_0_0_0_0_0_0_1_0_000_0_0_0;
  localparam logic [17:0] E_MEMRD  = 18'b0_0_0_0_1_0_0_0_0_0_0_1_000_1_0_0;
  localparam logic [17:0] E_FETCH3 = 18'b0_1_0_0_0_0_0_0_0_0_0_0_000_0_0_0;
  localparam logic [17:0] E_IDLE   = 18'b0_0_0_0_0_0_0_0_0_0_0_0_000_0_0_0;
  localparam logic [17:0] E_ADD    = 18'b0_0_1_0_0_1_0_0_0_0_0_0_000_0_0_0;
  localparam logic [17:0] E_AND    = 18'b0_0_1_0_0_1_0_0_0_0_0_0_001_0_0_0;
  localparam logic [17:0] E_NOT    = 18'b0_0_1_0_0_1_0_0_0_0_0_0_010_0_0_0;
  localparam logic [17:0] E_BRTAK  = 18'b1_0_0_0_0_0_1_0_0_0_0_0_000_0_0_0;
  localparam logic [17:0] E_CALC   = 18'b0_0_0_1_0_0_0_0_1_0_0_0_000_0_0_0;
  localparam logic [17:0] E_LDR2   = 18'b0_0_1_0_0_1_0_0_0_1_0_0_000_0_0_0;
  localparam logic [17:0] E_STR1   = 18'b0_0_0_0_1_0_0_1_0_0_0_0_011_0_0_0;
  localparam logic [17:0] E_STR2   = 18'b0_0_0_0_0_0_0_0_0_0_0_0_000_0_1_0;
  localparam logic [17:0] E_HALT   = 18'b0_0_0_0_0_0_0_0_0_0_0_0_000_0_0_1;

  function automatic logic [17:0] outvec();
    return {load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc,
            pcmux_sel, storemux_sel, alumux_sel, regfilemux_sel,
            marmux_sel, mdrmux_sel, aluop, mem.mem_read, mem.mem_write,
            illegal_op};
  endfunction

  task automatic check(input string tag, input logic [17:0] obs,
                       input logic [17:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic [17:0] exp);
    tick();
    check(tag, outvec(), exp);
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    rst           = 1'b1;
    opcode        = 4'b0000;
    branch_enable = 1'b0;
    mem.mem_resp  = 1'b0;

    #2;
    check("reset_fetch1", outvec(), E_FETCH1);
    check("byte_enable", {16'b0, mem.mem_byte_enable}, {16'b0, 2'b11});
    rst = 1'b0;

    // ADD, zero-wait fetch: 5 cycles FETCH1..FETCH1
    opcode = 4'b0001;
    step("add_fetch2", E_MEMRD);
    mem.mem_resp = 1'b1;
    step("add_fetch3", E_FETCH3);
    mem.mem_resp = 1'b0;
    step("add_decode", E_IDLE);
    step("add_exec", E_ADD);
    step("add_back_fetch1", E_FETCH1);

    // AND with mem_resp held high throughout (must be ignored outside waits)
    opcode = 4'b0101;
    mem.mem_resp = 1'b1;
    step("and_fetch2", E_MEMRD);
    step("and_fetch3", E_FETCH3);
    step("and_decode", E_IDLE);
    step("and_exec", E_AND);
    step("and_back_fetch1", E_FETCH1);
    mem.mem_resp = 1'b0;

    // NOT
    opcode = 4'b1001;
    step("not_fetch2", E_MEMRD);
    mem.mem_resp = 1'b1;
    step("not_fetch3", E_FETCH3);
    mem.mem_resp = 1'b0;
    step("not_decode", E_IDLE);
    step("not_exec", E_NOT);
    step("not_back_fetch1", E_FETCH1);

    // BR taken: 6 cycles
    opcode = 4'b0000;
    branch_enable = 1'b1;
    step("brt_fetch2", E_MEMRD);
    mem.mem_resp = 1'b1;
    step("brt_fetch3", E_FETCH3);
    mem.mem_resp = 1'b0;
    step("brt_decode", E_IDLE);
    step("brt_br", E_IDLE);
    step("brt_taken", E_BRTAK);
    step("brt_back_fetch1", E_FETCH1);

    // BR not taken: 5 cycles
    branch_enable = 1'b0;
    step("brn_fetch2", E_MEMRD);
    mem.mem_resp = 1'b1;
    step("brn_fetch3", E_FETCH3);
    mem.mem_resp = 1'b0;
    step("brn_decode", E_IDLE);
    step("brn_br", E_IDLE);
    step("brn_back_fetch1", E_FETCH1);

    // LDR with 3 wait cycles in LDR1 (4 LDR1 cycles total)
    opcode = 4'b0110;
    step("ldr_fetch2", E_MEMRD);
    mem.mem_resp = 1'b1;
    step("ldr_fetch3", E_FETCH3);
    mem.mem_resp = 1'b0;
    step("ldr_decode", E_IDLE);
    step("ldr_calc", E_CALC);
    step("ldr1_c1", E_MEMRD);
    step("ldr1_c2", E_MEMRD);
    step("ldr1_c3", E_MEMRD);
    step("ldr1_c4", E_MEMRD);
    mem.mem_resp = 1'b1;
    step("ldr2", E_LDR2);
    mem.mem_resp = 1'b0;
    step("ldr_back_fetch1", E_FETCH1);

    // STR with one wait in FETCH2 and one wait in STR2
    opcode = 4'b0111;
    step("str_fetch2_c1", E_MEMRD);
    step("str_fetch2_c2", E_MEMRD);
    mem.mem_resp = 1'b1;
    step("str_fetch3", E_FETCH3);
    mem.mem_resp = 1'b0;
    step("str_decode", E_IDLE);
    step("str_calc", E_CALC);
    step("str1", E_STR1);
    step("str2_c1", E_STR2);
    step("str2_c2", E_STR2);
    mem.mem_resp = 1'b1;
    step("str_back_fetch1", E_FETCH1);
    mem.mem_resp = 1'b0;

    // Unimplemented opcode 1101
    opcode = 4'b1101;
    step("ill_fetch2", E_MEMRD);
    mem.mem_resp = 1'b1;
    step("ill_fetch3", E_FETCH3);
    mem.mem_resp = 1'b0;
    step("ill_decode", E_IDLE);
`ifdef LC3B_CONTROL_ILLEGAL_TRAP_EN
    step("ill_halt_c1", E_HALT);
    mem.mem_resp = 1'b1;
    opcode = 4'b0001;
    step("ill_halt_c2", E_HALT);
    step("ill_halt_c3", E_HALT);
    mem.mem_resp = 1'b0;
    #4;
    rst = 1'b1;
    #1;
    check("ill_halt_reset", outvec(), E_FETCH1);
    rst = 1'b0;
`else
    step("ill_nop_fetch1", E_FETCH1);
`endif

    // Async reset while stalled in LDR1 with mem_read high
    opcode = 4'b0110;
    step("rst_fetch2", E_MEMRD);
    mem.mem_resp = 1'b1;
    step("rst_fetch3", E_FETCH3);
    mem.mem_resp = 1'b0;
    step("rst_decode", E_IDLE);
    step("rst_calc", E_CALC);
    step("rst_ldr1", E_MEMRD);
    #4;
    rst = 1'b1;
    #1;
    check("rst_async_fetch1", outvec(), E_FETCH1);
    mem.mem_resp = 1'b1;
    step("rst_held_fetch1", E_FETCH1);
    rst = 1'b0;
    mem.mem_resp = 1'b0;
    step("rst_after_fetch2", E_MEMRD);
    step("rst_after_fetch2_wait", E_MEMRD);
    mem.mem_resp = 1'b1;
    step("rst_after_fetch3", E_FETCH3);
    mem.mem_resp = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
